uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial receiver stage directly upstream of the keyboard buffer.
- Recovers 8N1 UART frames from the host serial line (USB-UART bridge, ASCII keystrokes).
- Presents each received byte on rx_data with a one-cycle rx_done strobe. This is exactly the rx_data/rx_done pair the keyboard buffer consumes.
- Flags malformed frames separately so the buffer never sees them.

Parameters:
- CLKS_PER_BIT, 868, system clock cycles per bit period (100 MHz / 115200 baud); minimum 8.
- CNT_W, 10, counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_serial  input  1  raw asynchronous UART line, idle high.
- rx_data  output  8  last correctly received byte, LSB first on the wire.
- rx_done  output  1  one-cycle pulse: rx_data newly valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- rx_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, rx_data 8'h00, rx_done 0, frame_err 0, rx_busy 0, bit counter 0, cycle counter 0, synchronizer flops 1.
- Synchronization:
  - rx_serial passes through 2 flops; rx_s is the second flop.
  - All decisions use rx_s only. Input-to-decision delay is 2 cycles.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s == 0 -> START, cycle counter cleared.
  - Otherwise remain.
- START:
  - Counter increments each cycle.
  - When counter == CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s.
  - Sample 0 -> DATA, counter cleared, bit index 0.
  - Sample 1 -> IDLE. This is a glitch rejection: no strobe, rx_data unchanged.
- DATA:
  - When counter == CLKS_PER_BIT - 1, sample rx_s into shift register bit position [bit index] (LSB first), clear counter.
  - After the sample at bit index 7 -> STOP. Otherwise increment bit index.
- STOP:
  - When counter == CLKS_PER_BIT - 1, sample rx_s.
  - Sample 1: rx_data <= shift register, rx_done = 1 for exactly the next cycle, -> IDLE.
  - Sample 0: frame_err = 1 for exactly one cycle, rx_data unchanged, -> BREAK.
- BREAK:
  - Wait until rx_s == 1, then -> IDLE.
  - Prevents a held-low line from generating repeated frames.
- rx_done and frame_err are never high simultaneously. Each is high for exactly one cycle per frame.
- rx_data holds its value until the next good frame. It is not cleared by rx_done falling.
- Latency: rx_done rises at roughly 9.5 bit periods + 3 cycles after the start-bit falling edge on rx_serial.
- Back-to-back frames:
  - A start bit immediately following the stop bit is detected from IDLE with no lost cycles.
  - The return to IDLE occurs mid-stop-bit, so the next falling edge is always caught.
- rx_busy = (state != IDLE). It is combinational from the state register.
- Reset mid-frame forces IDLE immediately. The partial byte is discarded and no strobe is issued. Reception resumes on the next falling edge after rst_n rises.
- The counter never wraps within a state; it is cleared on every sample point and on every state entry.

Test Plan:
- CLKS_PER_BIT=16, idle high for 20 cycles, then frame 0x68 (bits LSB first, stop 1) -> exactly one rx_done pulse; rx_data=8'h68; frame_err never asserts; rx_busy low afterwards.
- Frames 0x65, 0x6C, 0x6C, 0x6F sent back-to-back with no idle gap -> four rx_done pulses in order; rx_data=65,6C,6C,6F at each pulse; none dropped.
- Low glitch of 4 cycles on an idle line -> START aborts to IDLE; no rx_done or frame_err; rx_data retains 8'h6F.
- Frame 0x20 with stop bit forced 0, then line held low for 50 cycles, then high -> single frame_err pulse; no rx_done; rx_data unchanged; next frame 0x77 received correctly as 8'h77.
- rst_n pulsed low during data bit 4 of frame 0x72 -> outputs return to reset values asynchronously; no strobe; subsequent frame 0x64 yields rx_data=8'h64 with one rx_done.
- rst_n held low at power-up while rx_serial toggles -> rx_done, frame_err, and rx_busy all stay 0.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// -----------------------------------------------------------------------------
// uart_rx_byte_if
// Bundles the serial line and the received-byte outputs of uart_rx_byte.
//   rx_serial  : raw asynchronous UART line, idle high (into receiver)
//   rx_data    : last correctly received byte
//   rx_done    : one-cycle pulse, rx_data newly valid
//   frame_err  : one-cycle pulse, stop bit sampled low
//   rx_busy    : receiver is inside a frame (state not IDLE)
// master: the side that drives the line and consumes the byte stream.
// slave : the receiver itself.
// -----------------------------------------------------------------------------
interface uart_rx_byte_if;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_serial,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rx_serial,
        output rx_data,
        output rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver feeding the keyboard buffer. Each good frame updates
// rx_data and pulses rx_done for one cycle; a frame whose stop bit is low
// pulses frame_err instead and leaves rx_data untouched.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_byte_if.slave (rx_serial in; rx_data, rx_done,
//           frame_err, rx_busy out)
// Parameters:
//   CLKS_PER_BIT : clock cycles per bit period (>= 8)
//   CNT_W        : cycle counter width, 2**CNT_W > CLKS_PER_BIT
// -----------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_byte_if.slave        bus
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Start bit is checked at its midpoint; every later bit one full period on,
    // so data and stop bits are also sampled near their centres.
    localparam logic [CNT_W-1:0] HalfM1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FullM1 = CNT_W'(CLKS_PER_BIT - 1);

    state_e           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_done;
    logic             r_frame_err;
    logic             w_rx_s;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= bus.rx_serial;
            r_sync2     <= r_sync1;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (!w_rx_s) begin
                        r_state <= StStart;
                        r_cnt   <= '0;
                    end
                end

                StStart: begin
                    if (r_cnt == HalfM1) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state   <= StData;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid-bit: treat as glitch.
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StData: begin
                    if (r_cnt == FullM1) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StStop: begin
                    if (r_cnt == FullM1) begin
                        r_cnt <= '0;
                        // Leaving mid-stop-bit leaves half a bit in IDLE, so an
                        // immediately following start edge is never missed.
                        if (w_rx_s) begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= StBreak;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StBreak: begin
                    // Hold off until the line recovers so a stuck-low line
                    // cannot be decoded as a stream of 0x00 frames.
                    if (w_rx_s) begin
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_done   = r_rx_done;
    assign bus.frame_err = r_frame_err;
    assign bus.rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
// Directed bench for uart_rx_byte at CLKS_PER_BIT = 16. The line is driven
// and outputs are observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int unsigned Cpb = 16;

    logic clk;
    logic rst_n;

    uart_rx_byte_if u_if ();

    uart_rx_byte #(
        .CLKS_PER_BIT (Cpb),
        .CNT_W        (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Event counters maintained by the monitor; tests compare deltas.
    int         done_cnt;
    int         ferr_cnt;
    int         overlap_cnt;
    int         wide_cnt;
    logic [7:0] data_q[$];
    logic       prev_done;
    logic       prev_ferr;

    initial begin
        done_cnt    = 0;
        ferr_cnt    = 0;
        overlap_cnt = 0;
        wide_cnt    = 0;
        prev_done   = 1'b0;
        prev_ferr   = 1'b0;
    end

    always @(negedge clk) begin
        if (u_if.rx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            data_q.push_back(u_if.rx_data);
        end
        if (u_if.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
        if (u_if.rx_done === 1'b1 && u_if.frame_err === 1'b1) overlap_cnt = overlap_cnt + 1;
        if ((u_if.rx_done === 1'b1 && prev_done) || (u_if.frame_err === 1'b1 && prev_ferr))
            wide_cnt = wide_cnt + 1;
        prev_done = (u_if.rx_done === 1'b1);
        prev_ferr = (u_if.frame_err === 1'b1);
    end

    task automatic idle(input int cycles);
        u_if.rx_serial = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        u_if.rx_serial = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic test_power_up;
        int done_hi;
        int ferr_hi;
        int busy_hi;
        done_hi = 0;
        ferr_hi = 0;
        busy_hi = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            u_if.rx_serial = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (u_if.rx_done !== 1'b0) done_hi++;
            if (u_if.frame_err !== 1'b0) ferr_hi++;
            if (u_if.rx_busy !== 1'b0) busy_hi++;
        end
        n_tests++;
        if (done_hi !== 0) begin
            n_fail++;
            $display("FAIL power_up_done: rx_done high %0d cycles, required 0", done_hi);
        end
        n_tests++;
        if (ferr_hi !== 0) begin
            n_fail++;
            $display("FAIL power_up_ferr: frame_err high %0d cycles, required 0", ferr_hi);
        end
        n_tests++;
        if (busy_hi !== 0) begin
            n_fail++;
            $display("FAIL power_up_busy: rx_busy high %0d cycles, required 0", busy_hi);
        end
        u_if.rx_serial = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        idle(5);
        n_tests++;
        if (u_if.rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 00", u_if.rx_data);
        end
        n_tests++;
        if ({u_if.rx_done, u_if.frame_err, u_if.rx_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: done/ferr/busy got %b%b%b, required 000",
                     u_if.rx_done, u_if.frame_err, u_if.rx_busy);
        end
    endtask

    task automatic test_single;
        int   d0;
        int   f0;
        logic busy_mid;
        d0 = done_cnt;
        f0 = ferr_cnt;
        idle(20);
        send_bit(1'b0);
        busy_mid = u_if.rx_busy;
        for (int i = 0; i < 8; i++) send_bit(logic'((8'h68 >> i) & 8'h01));
        send_bit(1'b1);
        idle(20);
        n_tests++;
        if (busy_mid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_mid: got %b, required 1", busy_mid);
        end
        n_tests++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL single_done_count: got %0d, required 1", done_cnt - d0);
        end
        n_tests++;
        if (u_if.rx_data !== 8'h68) begin
            n_fail++;
            $display("FAIL single_data: got %h, required 68", u_if.rx_data);
        end
        n_tests++;
        if (ferr_cnt - f0 !== 0) begin
            n_fail++;
            $display("FAIL single_ferr: got %0d pulses, required 0", ferr_cnt - f0);
        end
        n_tests++;
        if (u_if.rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after: got %b, required 0", u_if.rx_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bytes[4];
        int         d0;
        int         q0;
        exp_bytes = '{8'h65, 8'h6C, 8'h6C, 8'h6F};
        d0 = done_cnt;
        q0 = data_q.size();
        for (int k = 0; k < 4; k++) send_byte(exp_bytes[k], 1'b1);
        idle(20);
        n_tests++;
        if (done_cnt - d0 !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, required 4", done_cnt - d0);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (q0 + k >= data_q.size()) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: no pulse, required %h", k, exp_bytes[k]);
            end else if (data_q[q0 + k] !== exp_bytes[k]) begin
                n_fail++;
                $display("FAIL b2b_byte%0d: got %h, required %h", k, data_q[q0 + k],
                         exp_bytes[k]);
            end
        end
    endtask

    task automatic test_glitch;
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        u_if.rx_serial = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        n_tests++;
        if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin
            n_fail++;
            $display("FAIL glitch_pulses: got done %0d ferr %0d, required 0 0",
                     done_cnt - d0, ferr_cnt - f0);
        end
        n_tests++;
        if (u_if.rx_data !== 8'h6F) begin
            n_fail++;
            $display("FAIL glitch_data: got %h, required 6F", u_if.rx_data);
        end
        n_tests++;
        if (u_if.rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %b, required 0", u_if.rx_busy);
        end
    endtask

    task automatic test_frame_error;
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_byte(8'h20, 1'b0);
        u_if.rx_serial = 1'b0;
        repeat (50) @(negedge clk);
        idle(30);
        n_tests++;
        if (ferr_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL ferr_count: got %0d pulses, required 1", ferr_cnt - f0);
        end
        n_tests++;
        if (done_cnt - d0 !== 0) begin
            n_fail++;
            $display("FAIL ferr_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        n_tests++;
        if (u_if.rx_data !== 8'h6F) begin
            n_fail++;
            $display("FAIL ferr_data_kept: got %h, required 6F", u_if.rx_data);
        end
        send_byte(8'h77, 1'b1);
        idle(20);
        n_tests++;
        if (done_cnt - d0 !== 1 || u_if.rx_data !== 8'h77) begin
            n_fail++;
            $display("FAIL ferr_recover: got %0d pulses data %h, required 1 pulse data 77",
                     done_cnt - d0, u_if.rx_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'h72 >> i) & 8'h01));
        u_if.rx_serial = 1'b1;  // data bit 4 of 0x72
        repeat (Cpb / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({u_if.rx_data, u_if.rx_done, u_if.frame_err, u_if.rx_busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL rst_mid_async: data %h done %b ferr %b busy %b, required 00 0 0 0",
                     u_if.rx_data, u_if.rx_done, u_if.frame_err, u_if.rx_busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        n_tests++;
        if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_strobe: got done %0d ferr %0d, required 0 0",
                     done_cnt - d0, ferr_cnt - f0);
        end
        send_byte(8'h64, 1'b1);
        idle(20);
        n_tests++;
        if (done_cnt - d0 !== 1 || u_if.rx_data !== 8'h64) begin
            n_fail++;
            $display("FAIL rst_mid_next: got %0d pulses data %h, required 1 pulse data 64",
                     done_cnt - d0, u_if.rx_data);
        end
    endtask

    task automatic test_pulse_shape;
        n_tests++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL pulse_overlap: got %0d cycles, required 0", overlap_cnt);
        end
        n_tests++;
        if (wide_cnt !== 0) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses, required 0", wide_cnt);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        u_if.rx_serial = 1'b1;
        test_power_up();
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
